// File: rtl/clmul_digit_serial.sv
// clmul_digit_serial: digit-serial carry-less multiplier, full product or reduced mod x^WIDTH+POLY
//   clk, rst            clock, asynchronous active-high reset
//   in_valid_i/ready_o  operand handshake (a_i, b_i, reduce_i latched on accept)
//   out_valid_o/ready_i result handshake (result_o held until consumed)
//   busy_o              high whenever an operation is in flight
module clmul_digit_serial #(
    parameter int WIDTH = 128,
    parameter int DIGIT = 8,
    parameter logic [WIDTH-1:0] POLY = 128'h87
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               reduce_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               busy_o
);
    localparam int NUM = WIDTH / DIGIT;
    localparam int CW = NUM > 1 ? $clog2(NUM) : 1;
    localparam int XW = WIDTH + DIGIT;

    function automatic int deg_f(input logic [WIDTH-1:0] p);
        int r;
        r = -1;
        for (int i = 0; i < WIDTH; i++) if (p[i]) r = i;
        return r;
    endfunction

    localparam int PDEG = deg_f(POLY);

    if (DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("clmul_digit_serial: DIGIT must be >= 1 and divide WIDTH");
    end
    if (PDEG + DIGIT > WIDTH) begin : g_bad_poly
        $error("clmul_digit_serial: deg(POLY) + DIGIT must not exceed WIDTH");
    end

    function automatic logic [XW-1:0] clmul_f(input logic [WIDTH-1:0] x, input logic [DIGIT-1:0] d);
        logic [XW-1:0] r;
        r = '0;
        for (int i = 0; i < DIGIT; i++) if (d[i]) r ^= XW'(x) << i;
        return r;
    endfunction

    // h * POLY always fits in WIDTH bits because deg(POLY) + DIGIT <= WIDTH
    function automatic logic [WIDTH-1:0] fold_f(input logic [DIGIT-1:0] h);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < DIGIT; i++) if (h[i]) r ^= POLY << i;
        return r;
    endfunction

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               red_q, red_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, res_q, res_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [XW-1:0]      prod, t_r;
    logic [2*WIDTH-1:0] t_f;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            red_q   <= 1'b0;
            acc_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            red_q   <= red_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    // b_q shifts left each CALC cycle so its top DIGIT bits are always the current (MSB-first) digit
    always_comb begin
        prod    = clmul_f(a_q, b_q[WIDTH-1 -: DIGIT]);
        t_f     = (acc_q << DIGIT) ^ (2*WIDTH)'(prod);
        t_r     = {acc_q[WIDTH-1:0], {DIGIT{1'b0}}} ^ prod;
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        red_d   = red_q;
        acc_d   = acc_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (in_valid_i) begin
                a_d     = a_i;
                b_d     = b_i;
                red_d   = reduce_i;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = CALC;
            end
            CALC: begin
                acc_d = red_q ? {{WIDTH{1'b0}}, t_r[WIDTH-1:0] ^ fold_f(t_r[XW-1 -: DIGIT])} : t_f;
                b_d   = b_q << DIGIT;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NUM - 1)) begin
                    res_d   = acc_d;
                    state_d = DONE;
                end
            end
            DONE: state_d = out_ready_i ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready_o  = state_q == IDLE;
    assign out_valid_o = state_q == DONE;
    assign busy_o      = state_q != IDLE;
    assign result_o    = res_q;
endmodule

// File: tb/tb_clmul_digit_serial.sv
// tb_clmul_digit_serial: directed and randomized checks of clmul_digit_serial for DIGIT in {8,1,4,32}
module tb_clmul_digit_serial;
    logic         clk = 1'b0;
    logic         rst_s[4], in_valid_s[4], in_ready_s[4], red_s[4], ov_s[4], ordy_s[4], busy_s[4];
    logic [127:0] a_s[4], b_s[4];
    logic [255:0] res_s[4];
    logic         go = 1'b0;
    logic         bp_ready = 1'b1;
    logic         done_s[4];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic ok, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    // Schoolbook product over GF(2), then long division by x^128 + x^7 + x^2 + x + 1
    function automatic logic [255:0] ref_mul(input logic [127:0] a, input logic [127:0] b, input logic red);
        logic [255:0] p, m;
        p = '0;
        for (int i = 0; i < 128; i++) if (b[i]) p ^= {128'b0, a} << i;
        m = {127'b0, 1'b1, 128'h87};
        if (red) for (int i = 255; i >= 128; i--) if (p[i]) p ^= m << (i - 128);
        return p;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    for (genvar k = 0; k < 4; k++) begin : g_lane
        localparam int D = k == 0 ? 8 : k == 1 ? 1 : k == 2 ? 4 : 32;
        localparam int NUM = 128 / D;
        localparam int NOPS = D == 1 ? 60 : 200;
        logic [255:0] q[$];
        int           acc_cyc = 0;
        logic         prev_ov = 1'b0;

        clmul_digit_serial #(.WIDTH(128), .DIGIT(D), .POLY(128'h87)) dut (
            .clk(clk), .rst(rst_s[k]), .in_valid_i(in_valid_s[k]), .in_ready_o(in_ready_s[k]),
            .a_i(a_s[k]), .b_i(b_s[k]), .reduce_i(red_s[k]), .out_valid_o(ov_s[k]),
            .out_ready_i(ordy_s[k]), .result_o(res_s[k]), .busy_o(busy_s[k])
        );

        initial begin
            ordy_s[k] = 1'b1;
            forever begin
                @(posedge clk);
                #2 ordy_s[k] = go ? ($urandom_range(0, 3) != 0) : (k == 0 ? bp_ready : 1'b1);
            end
        end

        always @(negedge clk) begin
            if (rst_s[k]) begin
                chk("reset_outputs", res_s[k] == '0 && !ov_s[k] && in_ready_s[k] && !busy_s[k], res_s[k], '0);
                q.delete();
                prev_ov = 1'b0;
            end else begin
                chk("ready_vs_busy", in_ready_s[k] == !busy_s[k], 256'(in_ready_s[k]), 256'(!busy_s[k]));
                if (ov_s[k]) chk("result", q.size() != 0 && res_s[k] == q[0], res_s[k], q.size() != 0 ? q[0] : '0);
                if (ov_s[k] && !prev_ov) chk("latency", cyc - acc_cyc == NUM + 1, 256'(cyc - acc_cyc - 1), 256'(NUM));
                if (ov_s[k] && ordy_s[k] && q.size() != 0) void'(q.pop_front());
                if (in_valid_s[k] && in_ready_s[k]) begin
                    q.push_back(ref_mul(a_s[k], b_s[k], red_s[k]));
                    acc_cyc = cyc;
                end
                prev_ov = ov_s[k];
            end
        end

        initial begin
            done_s[k] = 1'b0;
            in_valid_s[k] = 1'b0;
            a_s[k] = '0;
            b_s[k] = '0;
            red_s[k] = 1'b0;
            wait (go);
            for (int i = 0; i < 2 * NOPS; i++) begin
                int t;
                t = 0;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                @(posedge clk);
                #1;
                while (!in_ready_s[k] && t < 2000) begin
                    @(posedge clk);
                    #1 t++;
                end
                if (t >= 2000) chk("drive_timeout", 1'b0, 256'(t), '0);
                in_valid_s[k] = 1'b1;
                a_s[k] = $urandom_range(0, 7) == 0 ? '1 : rnd128();
                b_s[k] = $urandom_range(0, 7) == 0 ? '1 : rnd128();
                red_s[k] = i % 2 == 1;
                @(posedge clk);
                #1 in_valid_s[k] = 1'b0;
                a_s[k] = rnd128();
                b_s[k] = rnd128();
            end
            for (int t = 0; t < 2000 && !in_ready_s[k]; t++) @(posedge clk);
            if (!in_ready_s[k]) chk("drain_timeout", 1'b0, 256'(busy_s[k]), '0);
            done_s[k] = 1'b1;
        end
    end

    task automatic op0(input logic [127:0] a, input logic [127:0] b, input logic red,
                       output logic [255:0] r, output int lat);
        int n;
        n = 0;
        @(posedge clk);
        #1 in_valid_s[0] = 1'b1;
        a_s[0] = a;
        b_s[0] = b;
        red_s[0] = red;
        @(posedge clk);
        #1 in_valid_s[0] = 1'b0;
        a_s[0] = ~a;
        b_s[0] = rnd128();
        red_s[0] = ~red;
        while (n < 300) begin
            @(negedge clk);
            n++;
            chk("ready_low_busy", !in_ready_s[0], 256'(in_ready_s[0]), '0);
            if (ov_s[0]) break;
        end
        if (!ov_s[0]) chk("op_timeout", 1'b0, 256'(n), '0);
        lat = n - 1;
        r = res_s[0];
    endtask

    initial begin
        logic [127:0] hi, two, ones, ra, rb;
        logic [255:0] r, r0, five5;
        int lat, t;
        for (int k = 0; k < 4; k++) rst_s[k] = 1'b1;
        hi = 128'h1 << 127;
        two = 128'h2;
        ones = '1;
        five5 = {64{4'h5}};
        chk("model_red", ref_mul(hi, two, 1'b1) == 256'h87, ref_mul(hi, two, 1'b1), 256'h87);
        chk("model_ones", ref_mul(ones, ones, 1'b0) == five5, ref_mul(ones, ones, 1'b0), five5);
        chk("model_3x3", ref_mul(128'h3, 128'h3, 1'b0) == 256'h5, ref_mul(128'h3, 128'h3, 1'b0), 256'h5);
        repeat (3) @(posedge clk);
        #1 for (int k = 0; k < 4; k++) rst_s[k] = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", in_ready_s[0] && !ov_s[0] && !busy_s[0] && res_s[0] == '0, res_s[0], '0);

        op0(128'h1, 128'h1, 1'b0, r, lat);
        chk("one_x_one", r == 256'h1, r, 256'h1);
        chk("latency16", lat == 16, 256'(lat), 256'd16);
        op0(hi, two, 1'b0, r, lat);
        chk("x127_x_full", r == (256'h1 << 128), r, 256'h1 << 128);
        op0(hi, two, 1'b1, r, lat);
        chk("x127_x_red", r == 256'h87, r, 256'h87);
        op0(ones, ones, 1'b0, r, lat);
        chk("ones_sq", r == five5, r, five5);

        bp_ready = 1'b0;
        ra = rnd128() | 128'h1;
        rb = rnd128() | 128'h1;
        op0(ra, rb, 1'b0, r0, lat);
        chk("bp_result", r0 == ref_mul(ra, rb, 1'b0), r0, ref_mul(ra, rb, 1'b0));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 in_valid_s[0] = 1'b1;
            a_s[0] = rnd128();
            b_s[0] = ~rb;
            @(negedge clk);
            chk("bp_hold", ov_s[0] && !in_ready_s[0] && res_s[0] == r0, res_s[0], r0);
        end
        @(posedge clk);
        #1 in_valid_s[0] = 1'b0;
        bp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_consumed", !ov_s[0] && in_ready_s[0] && res_s[0] == r0, {ov_s[0], in_ready_s[0]}, 2'b01);

        @(posedge clk);
        #1 in_valid_s[0] = 1'b1;
        a_s[0] = ones;
        b_s[0] = ones;
        red_s[0] = 1'b0;
        @(posedge clk);
        #1 in_valid_s[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst_s[0] = 1'b1;
        #1 chk("rst_async", res_s[0] == '0 && !ov_s[0] && in_ready_s[0] && !busy_s[0], res_s[0], '0);
        @(posedge clk);
        #1 rst_s[0] = 1'b0;
        op0(128'h3, 128'h3, 1'b0, r, lat);
        chk("after_rst_3x3", r == 256'h5, r, 256'h5);
        chk("after_rst_lat", lat == 16, 256'(lat), 256'd16);

        go = 1'b1;
        t = 0;
        while (!(done_s[0] && done_s[1] && done_s[2] && done_s[3]) && t < 60000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 60000) chk("sweep_timeout", 1'b0, 256'(t), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
